// File: rtl/uart_tx_ctl.sv
// uart_tx_ctl: byte-wide valid/ready UART transmitter.
// It sends 8N1 or 8N2 frames, LSB first, at a baud rate set by parameters.
// Optional macro UART_TX_PARITY_EN adds a PARITY bit between DATA and STOP.
// With that macro, PARITY_ODD selects odd (1) or even (0) parity.
// All outputs are registered. Reset is synchronous and active-low on rst_pin.
module uart_tx_ctl #(
  parameter int unsigned CLOCK_RATE = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk_pin,
  input  logic       rst_pin,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd_pin,
  output logic       tx_busy
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DIVISOR = (CLOCK_RATE + (BAUD_RATE / 2)) / BAUD_RATE;
  localparam int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // Reject configurations that cannot produce a sensible bit period or frame.
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_ctl: CLOCK_RATE/BAUD_RATE must round to at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_ctl: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_ctl: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              txd_n, ready_n, busy_n;
  logic              baud_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_n;
`endif

  // State, datapath and output registers, cleared by a synchronous reset.
  always_ff @(posedge clk_pin) begin
    if (!rst_pin) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_pin  <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      shift_q  <= shift_n;
      txd_pin  <= txd_n;
      tx_ready <= ready_n;
      tx_busy  <= busy_n;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  // Next state and next values of the registered outputs.
  // txd_n is the bit that goes onto the line in the following cycle.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    shift_n   = shift_q;
    txd_n     = txd_pin;
    ready_n   = tx_ready;
    busy_n    = tx_busy;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity_q;
`endif
    baud_done = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_n = baud_done ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_n   = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
        if (tx_valid && tx_ready) begin
          state_n  = START;
          shift_n  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_n = (^tx_data) ^ 1'(PARITY_ODD);
`endif
          txd_n    = 1'b0;
          ready_n  = 1'b0;
          busy_n   = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          state_n = DATA;
          idx_n   = '0;
          txd_n   = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (idx_q == DATA_LAST) begin
            idx_n   = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = parity_q;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            idx_n   = idx_q + 1'b1;
            shift_n = {1'b0, shift_q[DATA_W-1:1]};
            txd_n   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_n = STOP;
          idx_n   = '0;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        if (baud_done) begin
          if (idx_q == STOP_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        txd_n   = 1'b1;
        ready_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Self-checking bench for uart_tx_ctl using directed frames.
// It runs four instances: 16 cycles/bit with 1 stop bit, 16 cycles/bit with 2 stop bits,
// 125 MHz at 115200 baud for a receive-side loopback, and an odd-parity variant.
module tb_uart_tx_ctl;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DIV      = 16;
  localparam int DIV_FAST = 1085;

  logic       clk;
  logic       rst_n    [4];
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       txd      [4];
  logic       tx_busy  [4];

  int checks = 0;
  int passed = 0;

  uart_tx_ctl #(.CLOCK_RATE(16), .BAUD_RATE(1), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk_pin(clk), .rst_pin(rst_n[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd_pin(txd[0]), .tx_busy(tx_busy[0]));
  uart_tx_ctl #(.CLOCK_RATE(16), .BAUD_RATE(1), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
    .clk_pin(clk), .rst_pin(rst_n[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd_pin(txd[1]), .tx_busy(tx_busy[1]));
  uart_tx_ctl #(.CLOCK_RATE(125_000_000), .BAUD_RATE(115_200), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
    .clk_pin(clk), .rst_pin(rst_n[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd_pin(txd[2]), .tx_busy(tx_busy[2]));
  uart_tx_ctl #(.CLOCK_RATE(16), .BAUD_RATE(1), .STOP_BITS(1), .PARITY_ODD(1)) u3 (
    .clk_pin(clk), .rst_pin(rst_n[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .txd_pin(txd[3]), .tx_busy(tx_busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int stops);
    return 1 + 8 + PB + stops;
  endfunction

  // Expected line bits of one frame: start, data LSB first, optional parity, then stop bits.
  function automatic logic [15:0] exp_frame(input logic [7:0] d, input int stops, input logic odd);
    logic [15:0] f;
    int i;
    f = '0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    i = 9;
    if (PB == 1) begin
      f[9] = (^d) ^ odd;
      i = 10;
    end
    for (int s = 0; s < stops; s++) f[i+s] = 1'b1;
    return f;
  endfunction

  // Record nbits line bits. Count cycles where txd changes inside a bit or busy is low.
  task automatic capture(input int sel, input int nbits, input int div,
                         output logic [15:0] bits, output int glitches);
    logic first;
    bits = '0;
    glitches = 0;
    for (int b = 0; b < nbits; b++) begin
      first = txd[sel];
      bits[b] = first;
      for (int c = 0; c < div; c++) begin
        if (txd[sel] !== first) glitches++;
        if (tx_busy[sel] !== 1'b1) glitches++;
        tick();
      end
    end
  endtask

  task automatic accept(input int sel, input logic [7:0] d);
    tx_data[sel]  = d;
    tx_valid[sel] = 1'b1;
    tick();
    tx_valid[sel] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; tx_valid[i] = 1'b0; tx_data[i] = 8'h00;
    end
    tick(); tick();
    checks++; if (txd[0] !== 1'b1) $display("FAIL rst_txd got=%b want=1", txd[0]); else passed++;
    checks++; if (tx_ready[0] !== 1'b0) $display("FAIL rst_ready got=%b want=0", tx_ready[0]); else passed++;
    checks++; if (tx_busy[0] !== 1'b0) $display("FAIL rst_busy got=%b want=0", tx_busy[0]); else passed++;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_ready[i] !== 1'b1) $display("FAIL rst_release_ready[%0d] got=%b want=1", i, tx_ready[i]);
      else passed++;
    end
  endtask

  task automatic test_frame_55();
    logic [15:0] bits;
    int gl;
    int n;
    n = frame_len(1);
    checks++; if (tx_busy[0] !== 1'b0) $display("FAIL f55_pre_busy got=%b want=0", tx_busy[0]); else passed++;
    accept(0, 8'h55);
    checks++; if (txd[0] !== 1'b0) $display("FAIL f55_start_txd got=%b want=0", txd[0]); else passed++;
    checks++; if (tx_ready[0] !== 1'b0) $display("FAIL f55_start_ready got=%b want=0", tx_ready[0]); else passed++;
    capture(0, n, DIV, bits, gl);
    checks++;
    if (bits !== exp_frame(8'h55, 1, 1'b0)) $display("FAIL f55_bits got=%h want=%h", bits, exp_frame(8'h55, 1, 1'b0));
    else passed++;
    checks++; if (gl !== 0) $display("FAIL f55_timing got=%0d want=0", gl); else passed++;
    checks++; if (tx_busy[0] !== 1'b0) $display("FAIL f55_end_busy got=%b want=0", tx_busy[0]); else passed++;
    checks++; if (tx_ready[0] !== 1'b1) $display("FAIL f55_end_ready got=%b want=1", tx_ready[0]); else passed++;
    checks++; if (txd[0] !== 1'b1) $display("FAIL f55_end_txd got=%b want=1", txd[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int gl;
    int n;
    n = frame_len(1);
    tx_data[0]  = 8'hA3;
    tx_valid[0] = 1'b1;
    tick();
    tx_data[0] = 8'h0F;
    capture(0, n, DIV, bits, gl);
    checks++;
    if (bits !== exp_frame(8'hA3, 1, 1'b0)) $display("FAIL b2b_a3_bits got=%h want=%h", bits, exp_frame(8'hA3, 1, 1'b0));
    else passed++;
    checks++; if (gl !== 0) $display("FAIL b2b_a3_timing got=%0d want=0", gl); else passed++;
    checks++; if (txd[0] !== 1'b1) $display("FAIL b2b_gap_txd got=%b want=1", txd[0]); else passed++;
    checks++; if (tx_ready[0] !== 1'b1) $display("FAIL b2b_gap_ready got=%b want=1", tx_ready[0]); else passed++;
    tick();
    tx_valid[0] = 1'b0;
    capture(0, n, DIV, bits, gl);
    checks++;
    if (bits !== exp_frame(8'h0F, 1, 1'b0)) $display("FAIL b2b_0f_bits got=%h want=%h", bits, exp_frame(8'h0F, 1, 1'b0));
    else passed++;
    checks++; if (gl !== 0) $display("FAIL b2b_0f_timing got=%0d want=0", gl); else passed++;
    checks++; if (tx_ready[0] !== 1'b1) $display("FAIL b2b_end_ready got=%b want=1", tx_ready[0]); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    int gl;
    accept(0, 8'hFF);
    // Start bit plus data bits 0..2 plus 5 cycles lands inside data bit 3.
    for (int i = 0; i < 16 + 48 + 5; i++) tick();
    checks++; if (tx_busy[0] !== 1'b1) $display("FAIL mid_busy_before got=%b want=1", tx_busy[0]); else passed++;
    rst_n[0] = 1'b0;
    tick();
    checks++; if (txd[0] !== 1'b1) $display("FAIL mid_rst_txd got=%b want=1", txd[0]); else passed++;
    checks++; if (tx_busy[0] !== 1'b0) $display("FAIL mid_rst_busy got=%b want=0", tx_busy[0]); else passed++;
    checks++; if (tx_ready[0] !== 1'b0) $display("FAIL mid_rst_ready got=%b want=0", tx_ready[0]); else passed++;
    rst_n[0] = 1'b1;
    tick();
    checks++; if (tx_ready[0] !== 1'b1) $display("FAIL mid_release_ready got=%b want=1", tx_ready[0]); else passed++;
    accept(0, 8'h00);
    capture(0, frame_len(1), DIV, bits, gl);
    checks++;
    if (bits !== exp_frame(8'h00, 1, 1'b0)) $display("FAIL mid_next_bits got=%h want=%h", bits, exp_frame(8'h00, 1, 1'b0));
    else passed++;
    checks++; if (gl !== 0) $display("FAIL mid_next_timing got=%0d want=0", gl); else passed++;
  endtask

  task automatic test_two_stop_bits();
    logic [15:0] bits;
    int gl;
    tx_data[1]  = 8'h80;
    tx_valid[1] = 1'b1;
    tick();
    tx_valid[1] = 1'b0;
    tx_data[1]  = 8'h7F;
    capture(1, frame_len(2), DIV, bits, gl);
    checks++;
    if (bits !== exp_frame(8'h80, 2, 1'b0)) $display("FAIL stop2_bits got=%h want=%h", bits, exp_frame(8'h80, 2, 1'b0));
    else passed++;
    checks++; if (gl !== 0) $display("FAIL stop2_timing got=%0d want=0", gl); else passed++;
    checks++; if (tx_busy[1] !== 1'b0) $display("FAIL stop2_end_busy got=%b want=0", tx_busy[1]); else passed++;
    checks++; if (tx_ready[1] !== 1'b1) $display("FAIL stop2_end_ready got=%b want=1", tx_ready[1]); else passed++;
  endtask

  task automatic test_parity();
    logic [15:0] bits;
    int gl;
`ifdef UART_TX_PARITY_EN
    accept(0, 8'h55);
    capture(0, 11, DIV, bits, gl);
    checks++; if (bits[9] !== 1'b0) $display("FAIL par_even_55 got=%b want=0", bits[9]); else passed++;
    checks++; if (gl !== 0) $display("FAIL par_even_55_timing got=%0d want=0", gl); else passed++;
    accept(0, 8'h01);
    capture(0, 11, DIV, bits, gl);
    checks++; if (bits[9] !== 1'b1) $display("FAIL par_even_01 got=%b want=1", bits[9]); else passed++;
    checks++; if (bits[10:0] !== 11'b1_1_00000001_0) $display("FAIL par_even_01_frame got=%h want=%h", bits[10:0], 11'b1_1_00000001_0); else passed++;
    checks++; if (tx_ready[0] !== 1'b1) $display("FAIL par_len_ready got=%b want=1", tx_ready[0]); else passed++;
    accept(3, 8'h01);
    capture(3, 11, DIV, bits, gl);
    checks++; if (bits[9] !== 1'b0) $display("FAIL par_odd_01 got=%b want=0", bits[9]); else passed++;
    checks++; if (gl !== 0) $display("FAIL par_odd_01_timing got=%0d want=0", gl); else passed++;
`else
    accept(3, 8'h01);
    capture(3, 10, DIV, bits, gl);
    checks++; if (bits[9:0] !== 10'b1_00000001_0) $display("FAIL nopar_frame got=%h want=%h", bits[9:0], 10'b1_00000001_0); else passed++;
    checks++; if (gl !== 0) $display("FAIL nopar_timing got=%0d want=0", gl); else passed++;
    checks++; if (tx_busy[3] !== 1'b0) $display("FAIL nopar_end_busy got=%b want=0", tx_busy[3]); else passed++;
`endif
  endtask

  // A receiver model samples u2's line at mid-bit and recovers the byte.
  task automatic test_loopback();
    logic [7:0] rx;
    int waited;
    rx = '0;
    accept(2, 8'h3C);
    waited = 0;
    while (txd[2] !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    for (int i = 0; i < DIV_FAST / 2; i++) tick();
    checks++; if (txd[2] !== 1'b0) $display("FAIL loop_start got=%b want=0", txd[2]); else passed++;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < DIV_FAST; i++) tick();
      rx[b] = txd[2];
    end
    checks++; if (rx !== 8'h3C) $display("FAIL loop_byte got=%h want=3c", rx); else passed++;
    waited = 0;
    while (tx_ready[2] !== 1'b1 && waited < 4 * DIV_FAST) begin
      tick();
      waited++;
    end
    checks++; if (tx_ready[2] !== 1'b1) $display("FAIL loop_ready_timeout got=%b want=1", tx_ready[2]); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop_bits();
    test_parity();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
